// File: rtl/sr_ctrl_pkg.sv
// rtl/sr_ctrl_pkg.sv - shared state encodings, op codes and legality helper for sr_flag_controller
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  // A command is legal only when exactly one of set/clr is asserted and the index exists in the bank.
  function automatic logic cmd_legal(input logic set, input logic clr,
                                     input int unsigned idx, input int unsigned nflag);
    return (set ^ clr) && (idx < nflag);
  endfunction

endpackage

// File: rtl/sr_flag_controller_if.sv
// rtl/sr_flag_controller_if.sv - requester command bus between producers and sr_flag_controller
interface sr_flag_controller_if #(
  parameter int NREQ = 4,
  parameter int IDXW = 3
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_set;
  logic [NREQ-1:0]      req_clr;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;

  modport master (output req_valid, output req_set, output req_clr, output req_idx,
                  input  req_ready);
  modport slave  (input  req_valid, input  req_set, input  req_clr, input  req_idx,
                  output req_ready);
endinterface

// File: rtl/sr_rr_arbiter.sv
// rtl/sr_rr_arbiter.sv - combinational round-robin pick of the first valid requester at or after the pointer
module sr_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_win
);

  logic w_found;
  int   w_j;

  // Walk the requesters starting at the pointer, wrapping once; the first valid one wins.
  always_comb begin
    o_grant = '0;
    o_win   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!w_found && i_valid[w_j]) begin
        w_found       = 1'b1;
        o_grant[w_j]  = 1'b1;
        o_win         = PW'(w_j);
      end
    end
  end

endmodule

// File: rtl/sr_flag_controller.sv
// rtl/sr_flag_controller.sv - arbitrates set/clear commands onto an SR flop bank; optional op counter under SR_CTRL_CNT_EN
module sr_flag_controller
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  sr_flag_controller_if.slave s_req,
  output logic [NFLAG-1:0] o_sr_s,
  output logic [NFLAG-1:0] o_sr_r,
  input  logic [NFLAG-1:0] i_flag_q,
  output logic             o_done,
  output logic             o_err
`ifdef SR_CTRL_CNT_EN
  ,
  output logic [15:0]      o_op_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_win;
  logic [NREQ-1:0]  w_grant;
  logic [NREQ-1:0]  r_grant;
  logic             w_any;
  logic             w_set;
  logic             w_clr;
  logic             w_legal;
  logic [IDXW-1:0]  w_idx;
  logic [IDXW-1:0]  r_idx;
  logic [NFLAG-1:0] w_dec;
  logic [NFLAG-1:0] r_sr_s;
  logic [NFLAG-1:0] r_sr_r;
  logic             r_op;
  logic             r_legal;
  logic             r_err;
  logic             w_q_sel;
  logic             w_match;

  assign w_any  = |s_req.req_valid;
  assign o_sr_s = r_sr_s;
  assign o_sr_r = r_sr_r;
  assign o_err  = r_err;

  sr_rr_arbiter #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_arb (
    .i_valid(s_req.req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_win  (w_win)
  );

  // Pull the winning requester's fields and decode its target flag to a one-hot bank vector.
  always_comb begin
    w_set   = s_req.req_set[w_win];
    w_clr   = s_req.req_clr[w_win];
    w_idx   = s_req.req_idx[int'(w_win)*IDXW +: IDXW];
    w_legal = cmd_legal(w_set, w_clr, 32'(w_idx), 32'(NFLAG));
    w_dec   = '0;
    for (int i = 0; i < NFLAG; i++) w_dec[i] = (w_idx == IDXW'(i));
  end

  // Select the captured flag's readback and compare it with the value the command should have left.
  always_comb begin
    w_q_sel = 1'b0;
    for (int i = 0; i < NFLAG; i++) begin
      if (r_idx == IDXW'(i)) w_q_sel = i_flag_q[i];
    end
    w_match = (w_q_sel == (r_op == OP_SET));
  end

  // Next-state: grant from IDLE, then one drive cycle and one check cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = ST_DRIVE;
      ST_DRIVE: w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Capture at grant, register the S/R drive for the DRIVE cycle only, and latch sticky errors in CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_idx   <= '0;
      r_op    <= OP_CLR;
      r_legal <= 1'b0;
      r_sr_s  <= '0;
      r_sr_r  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_sr_s <= '0;
      r_sr_r <= '0;
      if (r_state == ST_IDLE && w_any) begin
        r_grant <= w_grant;
        r_idx   <= w_idx;
        r_op    <= w_set ? OP_SET : OP_CLR;
        r_legal <= w_legal;
        r_ptr   <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
        if (w_legal && w_set)  r_sr_s <= w_dec;
        if (w_legal && !w_set) r_sr_r <= w_dec;
      end
      if (r_state == ST_CHECK && (!r_legal || !w_match)) r_err <= 1'b1;
    end
  end

  // Completion pulses are driven straight from the CHECK state.
  always_comb begin
    s_req.req_ready = '0;
    o_done          = 1'b0;
    if (r_state == ST_CHECK) begin
      s_req.req_ready = r_grant;
      o_done          = 1'b1;
    end
  end

`ifdef SR_CTRL_CNT_EN
  logic [15:0] r_op_cnt;

  // Count legal commands whose readback confirmed the update; wraps at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_op_cnt <= '0;
    else if (r_state == ST_CHECK && r_legal && w_match) r_op_cnt <= r_op_cnt + 16'd1;
  end

  assign o_op_cnt = r_op_cnt;
`endif

endmodule

// File: tb/tb_sr_flag_controller.sv
// tb/tb_sr_flag_controller.sv - self-checking bench for sr_flag_controller (also covers SR_CTRL_CNT_EN builds)
module tb_sr_flag_controller;

  localparam int NREQ  = 4;
  localparam int NFLAG = 8;
  localparam int IDXW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_flag_controller_if #(.NREQ(NREQ), .IDXW(IDXW)) if8 ();
  sr_flag_controller_if #(.NREQ(NREQ), .IDXW(IDXW)) if6 ();

  logic [7:0] sr_s, sr_r, flag_q, bank;
  logic [7:0] stuck0 = '0;
  logic       done, err;
  logic [5:0] sr_s6, sr_r6, flag_q6, bank6;
  logic       done6, err6;
`ifdef SR_CTRL_CNT_EN
  logic [15:0] op_cnt, op_cnt6;
`endif

  sr_flag_controller #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .s_req(if8),
    .o_sr_s(sr_s), .o_sr_r(sr_r), .i_flag_q(flag_q), .o_done(done), .o_err(err)
`ifdef SR_CTRL_CNT_EN
    , .o_op_cnt(op_cnt)
`endif
  );

  sr_flag_controller #(.NREQ(NREQ), .NFLAG(6), .IDXW(IDXW)) dut6 (
    .clk(clk), .rst(rst), .s_req(if6),
    .o_sr_s(sr_s6), .o_sr_r(sr_r6), .i_flag_q(flag_q6), .o_done(done6), .o_err(err6)
`ifdef SR_CTRL_CNT_EN
    , .o_op_cnt(op_cnt6)
`endif
  );

  // SR flop bank models: S sets, R clears, otherwise hold.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bank  <= '0;
      bank6 <= '0;
    end else begin
      bank  <= (bank | sr_s) & ~sr_r;
      bank6 <= (bank6 | sr_s6) & ~sr_r6;
    end
  end
  assign flag_q  = bank & ~stuck0;
  assign flag_q6 = bank6;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state kept at transaction level.
  logic        m_err;
  int          m_ptr;
  logic [7:0]  m_bank;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    n_cmp++;
    if ((sr_s & sr_r) != 0 || (sr_s6 & sr_r6) != 0) begin
      n_bad++;
      $display("FAIL sr_overlap: s=%h r=%h s6=%h r6=%h, expected no common bit", sr_s, sr_r, sr_s6, sr_r6);
    end
  end

  task automatic set_req(input int i, input bit v, input bit s, input bit c, input int idx);
    if8.req_valid[i] = v;
    if8.req_set[i]   = s;
    if8.req_clr[i]   = c;
    if8.req_idx[i*IDXW +: IDXW] = IDXW'(idx);
  endtask

  task automatic set_req6(input int i, input bit v, input bit s, input bit c, input int idx);
    if6.req_valid[i] = v;
    if6.req_set[i]   = s;
    if6.req_clr[i]   = c;
    if6.req_idx[i*IDXW +: IDXW] = IDXW'(idx);
  endtask

  task automatic clear_reqs();
    if8.req_valid = '0; if8.req_set = '0; if8.req_clr = '0; if8.req_idx = '0;
    if6.req_valid = '0; if6.req_set = '0; if6.req_clr = '0; if6.req_idx = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    stuck0 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_err = 1'b0; m_ptr = 0; m_bank = '0; m_cnt = '0;
  endtask

  // Called at an IDLE negedge with requester win's command already on the bus and chosen as winner.
  // Returns at the IDLE negedge following CHECK.
  task automatic cmd_cycle(input int win, input bit set, input bit clr, input int idx, input string tag);
    logic [7:0] es, er;
    bit legal, match;
    legal = (set != clr) && (idx < NFLAG);
    es = '0; er = '0; match = 1'b0;
    if (legal) begin
      if (set) es[idx] = 1'b1;
      else     er[idx] = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_drive_s"}, sr_s, es);
    chk({tag, "_drive_r"}, sr_r, er);
    chk({tag, "_drive_ready"}, if8.req_ready, 0);
    @(negedge clk);
    chk({tag, "_check_ready"}, if8.req_ready, 32'(1) << win);
    chk({tag, "_check_done"}, done, 1);
    chk({tag, "_check_sr"}, sr_s | sr_r, 0);
    if8.req_valid[win] = 1'b0;
    if (legal) begin
      m_bank[idx] = set;
      match = ((m_bank[idx] & ~stuck0[idx]) == set);
    end
    if (!legal || !match) m_err = 1'b1;
    if (legal && match) m_cnt = m_cnt + 16'd1;
    @(negedge clk);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_idle_done"}, done, 0);
`ifdef SR_CTRL_CNT_EN
    chk({tag, "_cnt"}, op_cnt, m_cnt);
`endif
  endtask

  typedef struct {
    int         req;
    bit         set;
    bit         clr;
    int         idx;
    logic [7:0] es;
    logic [7:0] er;
    bit         eerr;
  } vec_t;

  vec_t tbl[7];

  logic [NREQ-1:0] pend;
  bit              ps[NREQ];
  bit              pc[NREQ];
  int              pi[NREQ];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 1'b1, 1'b0, 3, 8'h08, 8'h00, 1'b0};
    tbl[1] = '{1, 1'b0, 1'b1, 3, 8'h00, 8'h08, 1'b0};
    tbl[2] = '{2, 1'b1, 1'b0, 7, 8'h80, 8'h00, 1'b0};
    tbl[3] = '{3, 1'b0, 1'b1, 0, 8'h00, 8'h01, 1'b0};
    tbl[4] = '{2, 1'b1, 1'b1, 5, 8'h00, 8'h00, 1'b1};
    tbl[5] = '{1, 1'b0, 1'b0, 2, 8'h00, 8'h00, 1'b1};
    tbl[6] = '{3, 1'b1, 1'b0, 0, 8'h01, 8'h00, 1'b0};

    // Reset values.
    rst = 1'b1;
    clear_reqs();
    @(negedge clk);
    chk("rst_sr_s", sr_s, 0);
    chk("rst_sr_r", sr_r, 0);
    chk("rst_ready", if8.req_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sr6", {sr_s6, sr_r6}, 0);
    chk("rst_err6", err6, 0);
`ifdef SR_CTRL_CNT_EN
    chk("rst_cnt", op_cnt, 0);
`endif

    // Single-requester vectors, each from a fresh reset.
    for (int t = 0; t < 7; t++) begin
      do_reset();
      set_req(tbl[t].req, 1'b1, tbl[t].set, tbl[t].clr, tbl[t].idx);
      @(negedge clk);
      chk($sformatf("tbl%0d_s", t), sr_s, tbl[t].es);
      chk($sformatf("tbl%0d_r", t), sr_r, tbl[t].er);
      chk($sformatf("tbl%0d_ready_early", t), if8.req_ready, 0);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", t), if8.req_ready, 32'(1) << tbl[t].req);
      chk($sformatf("tbl%0d_done", t), done, 1);
      clear_reqs();
      @(negedge clk);
      chk($sformatf("tbl%0d_err", t), err, tbl[t].eerr);
    end

    // Contention: four CLR commands granted 0,1,2,3, then pointer back at 0.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 1'b1, i);
    for (int k = 0; k < NREQ; k++) cmd_cycle(k, 1'b0, 1'b1, k, $sformatf("cont%0d", k));
    set_req(0, 1'b1, 1'b1, 1'b0, 4);
    set_req(3, 1'b1, 1'b1, 1'b0, 5);
    cmd_cycle(0, 1'b1, 1'b0, 4, "cont_ptr0");
    cmd_cycle(3, 1'b1, 1'b0, 5, "cont_ptr3");

    // Readback mismatch: flag 1 held low after a SET.
    do_reset();
    stuck0 = 8'h02;
    set_req(0, 1'b1, 1'b1, 1'b0, 1);
    cmd_cycle(0, 1'b1, 1'b0, 1, "mismatch");
    chk("mismatch_err", err, 1);
    stuck0 = '0;

    // Reset during DRIVE aborts the command and clears the sticky error and pointer.
    do_reset();
    set_req(1, 1'b1, 1'b1, 1'b1, 2);
    cmd_cycle(1, 1'b1, 1'b1, 2, "rst_ill");
    set_req(2, 1'b1, 1'b1, 1'b0, 4);
    @(negedge clk);
    chk("rstmid_drive", sr_s, 8'h10);
    rst = 1'b1;
    #1;
    chk("rstmid_s", sr_s, 0);
    chk("rstmid_r", sr_r, 0);
    chk("rstmid_ready", if8.req_ready, 0);
    chk("rstmid_err", err, 0);
    clear_reqs();
    @(negedge clk);
    rst = 1'b0;
    m_err = 1'b0; m_ptr = 0; m_bank = '0; m_cnt = '0;
    set_req(0, 1'b1, 1'b1, 1'b0, 6);
    set_req(3, 1'b1, 1'b1, 1'b0, 7);
    cmd_cycle(0, 1'b1, 1'b0, 6, "rstmid_after0");
    cmd_cycle(3, 1'b1, 1'b0, 7, "rstmid_after3");

    // Six-flag bank: in-range SET drives, out-of-range index drives nothing and flags an error.
    do_reset();
    set_req6(1, 1'b1, 1'b1, 1'b0, 5);
    @(negedge clk);
    chk("nf6_s", sr_s6, 6'h20);
    chk("nf6_r", sr_r6, 0);
    @(negedge clk);
    chk("nf6_ready", if6.req_ready, 4'b0010);
    chk("nf6_done", done6, 1);
    clear_reqs();
    @(negedge clk);
    chk("nf6_err_ok", err6, 0);
    set_req6(2, 1'b1, 1'b1, 1'b0, 7);
    @(negedge clk);
    chk("nf6_oor_sr", {sr_s6, sr_r6}, 0);
    @(negedge clk);
    chk("nf6_oor_ready", if6.req_ready, 4'b0100);
    chk("nf6_oor_done", done6, 1);
    clear_reqs();
    @(negedge clk);
    chk("nf6_oor_err", err6, 1);
    @(negedge clk);
    chk("nf6_err_sticky", err6, 1);

`ifdef SR_CTRL_CNT_EN
    // Counter: three legal, one illegal.
    do_reset();
    set_req(0, 1'b1, 1'b1, 1'b0, 1); cmd_cycle(0, 1'b1, 1'b0, 1, "cnt_a");
    set_req(1, 1'b1, 1'b0, 1'b1, 1); cmd_cycle(1, 1'b0, 1'b1, 1, "cnt_b");
    set_req(2, 1'b1, 1'b1, 1'b0, 6); cmd_cycle(2, 1'b1, 1'b0, 6, "cnt_c");
    set_req(3, 1'b1, 1'b0, 1'b0, 2); cmd_cycle(3, 1'b0, 1'b0, 2, "cnt_ill");
    chk("cnt_total", op_cnt, 3);
`endif

    // Randomized traffic against the transaction-level model.
    pend = '0;
    for (int n = 0; n < 200; n++) begin
      if (n % 25 == 0) begin
        do_reset();
        pend = '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          int r;
          r = int'($urandom_range(0, 19));
          ps[i] = (r < 9) || (r == 18);
          pc[i] = (r >= 9 && r < 18) || (r == 18);
          pi[i] = int'($urandom_range(0, NFLAG - 1));
          set_req(i, 1'b1, ps[i], pc[i], pi[i]);
          pend[i] = 1'b1;
        end
      end
      if (pend == '0) begin
        chk("rand_idle_ready", if8.req_ready, 0);
        @(negedge clk);
      end else begin
        int win;
        stuck0 = ($urandom_range(0, 7) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (win < 0 && pend[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
        end
        m_ptr = (win + 1) % NREQ;
        cmd_cycle(win, ps[win], pc[win], pi[win], $sformatf("rand%0d", n));
        pend[win] = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
